// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Definitions shared by the fetch stage and its IF/ID register:
//     NOP_INSTR       canonical bubble instruction (addi x0, x0, 0)
//     RS1_* / RS2_*   bit positions of the source-register fields
//     fetch_state_e   fetch FSM states
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int RS2_LSB = 20;
   localparam int RS2_MSB = 24;

   // IDLE : one cycle after reset, nothing in flight
   // REQ  : request presented, waiting for the memory handshake
   // WAIT : one request outstanding, waiting for its response
   // HOLD : response captured while stalled, parked in the hold buffer
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Priority, highest first:
//     flush : drop contents (valid=0, instr=NOP); pc is left as is
//     stall : hold every field
//     load  : capture {1, load_pc, load_instr}
//     else  : bubble (valid=0, instr=NOP); pc is left as is
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     stall, flush, load           control, see priority above
//     load_pc, load_instr          data captured on load
//     id_valid, id_pc, id_instr    register contents
// ---------------------------------------------------------------------------
module if_id_reg
   import riscv_pkg::*;
#(
   parameter int WORD_BITWIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     load,
   input  logic [WORD_BITWIDTH-1:0] load_pc,
   input  logic [WORD_BITWIDTH-1:0] load_instr,
   output logic                     id_valid,
   output logic [WORD_BITWIDTH-1:0] id_pc,
   output logic [WORD_BITWIDTH-1:0] id_instr
);

   localparam logic [WORD_BITWIDTH-1:0] NOP = WORD_BITWIDTH'(NOP_INSTR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_instr <= NOP;
      end else if (flush) begin
         id_valid <= 1'b0;
         id_instr <= NOP;
      end else if (!stall) begin
         if (load) begin
            id_valid <= 1'b1;
            id_pc    <= load_pc;
            id_instr <= load_instr;
         end else begin
            id_valid <= 1'b0;
            id_instr <= NOP;
         end
      end
   end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage: owns the PC, issues one outstanding request at a
//   time to instruction memory, parks a response that arrives during a stall
//   in a one-entry hold buffer, and feeds the IF/ID register.
//
//   Handshake semantics:
//     request  : a transfer happens on a rising edge where imem_req_valid and
//                imem_req_ready are both 1. While valid is 1 and ready is 0,
//                imem_req_addr stays stable and valid stays asserted
//                (unless a redirect replaces the address).
//     response : no ready; imem_rsp_valid is always accepted. It is only
//                meaningful in WAIT; at any other time it is ignored.
//
//   Ports:
//     clk, rst_n                          clock, async active-low reset
//     if_stall                            freeze PC and IF/ID
//     redirect_valid, redirect_pc         EX redirect (pc[1:0] forced to 0)
//     imem_req_valid/ready/addr           fetch request channel
//     imem_rsp_valid/data                 fetch response channel
//     id_valid, id_pc, id_instr           IF/ID register contents
//     id_Rs1, id_Rs2                      source-register fields of id_instr
// ---------------------------------------------------------------------------
module if_stage
   import riscv_pkg::*;
#(
   parameter int                       WORD_BITWIDTH    = 32,
   parameter int                       REG_NUM_BITWIDTH = 5,
   parameter logic [WORD_BITWIDTH-1:0] RESET_PC         = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        if_stall,
   input  logic                        redirect_valid,
   input  logic [WORD_BITWIDTH-1:0]    redirect_pc,
   output logic                        imem_req_valid,
   input  logic                        imem_req_ready,
   output logic [WORD_BITWIDTH-1:0]    imem_req_addr,
   input  logic                        imem_rsp_valid,
   input  logic [WORD_BITWIDTH-1:0]    imem_rsp_data,
   output logic                        id_valid,
   output logic [WORD_BITWIDTH-1:0]    id_pc,
   output logic [WORD_BITWIDTH-1:0]    id_instr,
   output logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
   output logic [REG_NUM_BITWIDTH-1:0] id_Rs2
);

   localparam logic [WORD_BITWIDTH-1:0] PC_STEP    = WORD_BITWIDTH'(4);
   localparam logic [WORD_BITWIDTH-1:0] ALIGN_MASK = ~WORD_BITWIDTH'(3);

   fetch_state_e               state, state_n;
   logic [WORD_BITWIDTH-1:0]   pc, pc_n;
   logic                       kill, kill_n;
   logic                       hold_valid, hold_valid_n;
   logic [WORD_BITWIDTH-1:0]   hold_data, hold_data_n;

   logic                       req_fire;
   logic                       id_load;
   logic                       id_flush;
   logic [WORD_BITWIDTH-1:0]   id_load_pc;
   logic [WORD_BITWIDTH-1:0]   id_load_instr;

   // pc always holds the address of the request being presented or awaited,
   // so the address output is simply pc.
   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         kill       <= kill_n;
         hold_valid <= hold_valid_n;
         hold_data  <= hold_data_n;
      end
   end

   always_comb begin
      state_n       = state;
      pc_n          = pc;
      kill_n        = kill;
      hold_valid_n  = hold_valid;
      hold_data_n   = hold_data;
      id_load       = 1'b0;
      id_flush      = 1'b0;
      id_load_pc    = pc;
      id_load_instr = imem_rsp_data;

      case (state)
         IDLE: state_n = REQ;

         REQ: begin
            if (req_fire) state_n = WAIT;
         end

         WAIT: begin
            if (imem_rsp_valid) begin
               if (kill) begin
                  // response belongs to a fetch made stale by a redirect
                  kill_n  = 1'b0;
                  state_n = REQ;
               end else if (!if_stall) begin
                  id_load = 1'b1;
                  pc_n    = pc + PC_STEP;
                  state_n = REQ;
               end else begin
                  hold_data_n  = imem_rsp_data;
                  hold_valid_n = 1'b1;
                  pc_n         = pc + PC_STEP;
                  state_n      = HOLD;
               end
            end
         end

         HOLD: begin
            if (!if_stall) begin
               // pc already points past the parked instruction
               id_load       = 1'b1;
               id_load_pc    = pc - PC_STEP;
               id_load_instr = hold_data;
               hold_valid_n  = 1'b0;
               state_n       = REQ;
            end
         end

         default: state_n = IDLE;
      endcase

      // Redirect overrides everything above, stall included.
      if (redirect_valid) begin
         pc_n         = redirect_pc & ALIGN_MASK;
         id_flush     = 1'b1;
         id_load      = 1'b0;
         hold_valid_n = 1'b0;
         case (state)
            REQ: begin
               if (req_fire) begin
                  // old address already accepted: its response must be dropped
                  state_n = WAIT;
                  kill_n  = 1'b1;
               end else begin
                  state_n = REQ;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  state_n = REQ;
                  kill_n  = 1'b0;
               end else begin
                  state_n = WAIT;
                  kill_n  = 1'b1;
               end
            end
            default: begin
               state_n = REQ;
               kill_n  = 1'b0;
            end
         endcase
      end
   end

   if_id_reg #(
      .WORD_BITWIDTH (WORD_BITWIDTH)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (if_stall),
      .flush      (id_flush),
      .load       (id_load),
      .load_pc    (id_load_pc),
      .load_instr (id_load_instr),
      .id_valid   (id_valid),
      .id_pc      (id_pc),
      .id_instr   (id_instr)
   );

   assign id_Rs1 = id_instr[RS1_MSB:RS1_LSB];
   assign id_Rs2 = id_instr[RS2_MSB:RS2_LSB];

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC, issues single-outstanding requests to instruction memory, and holds the IF/ID pipeline register.
- Consumes the stall from the load-use hazard unit and the taken-branch/jump redirect from EX.
- Exports ID-stage PC/instruction and the Rs1/Rs2 fields the hazard unit compares against the ID-stage load destination.

Parameters:
- WORD_BITWIDTH, 32, width of PC, addresses and instructions.
- REG_NUM_BITWIDTH, 5, width of register-number fields.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- if_stall  in  1  hazard stall; freezes PC and IF/ID.
- redirect_valid  in  1  EX redirect strobe.
- redirect_pc  in  WORD_BITWIDTH  redirect target; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  WORD_BITWIDTH  fetch address.
- imem_rsp_valid  in  1  response valid; always accepted.
- imem_rsp_data  in  WORD_BITWIDTH  fetched instruction.
- id_valid  out  1  IF/ID holds a real instruction.
- id_pc  out  WORD_BITWIDTH  PC of the IF/ID instruction.
- id_instr  out  WORD_BITWIDTH  IF/ID instruction.
- id_Rs1  out  REG_NUM_BITWIDTH  id_instr[19:15], combinational.
- id_Rs2  out  REG_NUM_BITWIDTH  id_instr[24:20], combinational.

Behaviour:
- Reset values:
  - state = IDLE.
  - pc = RESET_PC.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - id_valid = 0, id_pc = 0, id_instr = NOP (32'h0000_0013), so id_Rs1 = id_Rs2 = 0.
  - kill = 0, hold_valid = 0.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - Entered only from reset.
  - Moves to REQ on the next clock.
- REQ:
  - imem_req_valid = 1, imem_req_addr = pc; both held stable until imem_req_ready.
  - On handshake, go to WAIT.
- WAIT:
  - Waits for imem_rsp_valid.
  - If kill = 1: discard the response, clear kill, go to REQ.
  - If kill = 0 and if_stall = 0: load IF/ID with {valid=1, pc, rsp_data}, set pc = pc + 4, go to REQ.
  - If kill = 0 and if_stall = 1: write rsp_data into the hold buffer, set hold_valid = 1, set pc = pc + 4, go to HOLD.
- HOLD:
  - No request issued.
  - When if_stall = 0: load IF/ID from the hold buffer (id_pc = pc - 4), clear hold_valid, go to REQ.
- IF/ID update when if_stall = 0 and no new data: id_valid <= 0 and id_instr <= NOP (bubble).
- IF/ID update when if_stall = 1: all id_* registers hold their value.
- Redirect has priority over everything, including if_stall:
  - pc <= redirect_pc.
  - IF/ID flushed (id_valid = 0, id_instr = NOP).
  - hold_valid cleared.
  - Next state depends on the state during the redirect cycle:
    - REQ without handshake: stay in REQ; the new address appears next cycle.
    - REQ with handshake: go to WAIT with kill = 1.
    - WAIT with a response in the same cycle: discard the response, go to REQ.
    - WAIT without a response: kill = 1, stay in WAIT.
    - HOLD: go to REQ.
    - IDLE: go to REQ.
- Latency and throughput:
  - Request accepted at cycle N, response at N+1, id_valid visible at N+2.
  - Zero-wait memory yields one instruction every 2 cycles.
- Arithmetic: pc + 4 wraps modulo 2^WORD_BITWIDTH, so 0xFFFF_FFFC is followed by 0.
- Outstanding requests: at most one. A response outside WAIT is a protocol violation; the bench checks it never occurs.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight response is ignored because state = IDLE.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR.
  - RS1_LSB/MSB and RS2_LSB/MSB field positions.
  - The fetch state enum {IDLE, REQ, WAIT, HOLD}.
- One sub-module, if_id_reg: the IF/ID register with stall-hold, flush and load priority. This module keeps the FSM, PC and hold buffer.

Test Plan:
- Release reset, memory ready = 1, 1-cycle response returning addr^0xA5A5_A5A5 -> imem_req_addr sequence 0, 4, 8; id_pc 0, 4, 8 with id_valid every other cycle; first id_valid 3 cycles after rst_n rises.
- if_stall = 1 in the cycle the response for 0x8 arrives, held 3 cycles -> no new request while stalled; id_* frozen at pc 0x4; on release id_pc = 0x8 with the correct data; next request addr = 0xC.
- redirect_valid with redirect_pc = 0x100 while in WAIT, response arriving 2 cycles later -> that response discarded; id_valid stays 0; next request addr = 0x100; id_pc = 0x100 is the next valid instruction.
- redirect_valid and if_stall in the same cycle with id_valid = 1 -> IF/ID flushed (id_valid = 0, id_instr = 0x13, id_Rs1 = id_Rs2 = 0); next request addr = redirect target.
- imem_req_ready low 3 cycles in REQ -> imem_req_valid = 1 and imem_req_addr stable all 3 cycles; pc unchanged.
- Redirect to 0xFFFF_FFFC, then fetch -> next request addr = 0x0000_0000.
